// File: rtl/lsu_dmem_unit.sv
// lsu_dmem_unit: MEM-stage load/store unit for the rv32i pipeline.
// Runs a req/ready/rvalid handshake with data memory, formats load data
// and holds the pipeline while an access is outstanding.
// Optional build macro: LSU_TIMEOUT_EN adds a wait counter that aborts an
// access after TIMEOUT_CYCLES cycles without a memory response.
module lsu_dmem_unit #(
    parameter int unsigned TIMEOUT_CYCLES = 255
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic        ex_valid,
    input  logic        mem_read,
    input  logic        mem_write,
    input  logic [2:0]  funct3,
    input  logic [31:0] addr,
    input  logic [31:0] store_data,
    output logic        lsu_stall,
    output logic [31:0] load_data,
    output logic        load_valid,
    output logic        store_done,
    output logic        access_fault,
    output logic        dmem_req,
    output logic        dmem_we,
    output logic [31:0] dmem_addr,
    output logic [31:0] dmem_wdata,
    output logic [3:0]  dmem_be,
    input  logic        dmem_ready,
    input  logic        dmem_rvalid,
    input  logic [31:0] dmem_rdata
);

    typedef enum logic [1:0] {
        IDLE,
        REQ,
        RESP,
        DONE
    } state_e;

    state_e      state_q, state_d;

    logic        dmemReq_q, dmemReq_d;
    logic        dmemWe_q, dmemWe_d;
    logic [31:0] dmemAddr_q, dmemAddr_d;
    logic [31:0] dmemWdata_q, dmemWdata_d;
    logic [3:0]  dmemBe_q, dmemBe_d;
    logic [2:0]  funct3_q, funct3_d;
    logic [1:0]  offset_q, offset_d;
    logic        isStore_q, isStore_d;
    logic [31:0] loadData_q, loadData_d;
    logic        loadValid_q, loadValid_d;
    logic        storeDone_q, storeDone_d;
    logic        accessFault_q, accessFault_d;

    logic        start;
    logic        isStore;
    logic        illegal;
    logic [3:0]  beReq;
    logic [31:0] wdataReq;
    logic [7:0]  selByte;
    logic [15:0] selHalf;
    logic [31:0] fmtData;
    logic        timeoutHit;

    // The parameter only makes sense as an 8-bit non-zero limit.
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 255) begin : g_timeoutRange
        $error("lsu_dmem_unit: TIMEOUT_CYCLES must be in 1..255");
    end

    // A write-only request is a store; read+write together counts as a load.
    assign isStore = mem_write & ~mem_read;
    assign start   = (state_q == IDLE) & ex_valid & (mem_read | mem_write);

    // Alignment and encoding legality of the incoming request.
    always_comb begin
        illegal = 1'b0;
        case (funct3)
            3'b000:  illegal = 1'b0;
            3'b001:  illegal = addr[0];
            3'b010:  illegal = (addr[1:0] != 2'b00);
            3'b100:  illegal = isStore;
            3'b101:  illegal = isStore | addr[0];
            default: illegal = 1'b1;
        endcase
    end

    // Byte enables and lane-replicated write data for the incoming request.
    always_comb begin
        beReq    = 4'b1111;
        wdataReq = store_data;
        case (funct3[1:0])
            2'b00: begin
                beReq    = 4'b0001 << addr[1:0];
                wdataReq = {4{store_data[7:0]}};
            end
            2'b01: begin
                beReq    = 4'b0011 << {addr[1], 1'b0};
                wdataReq = {2{store_data[15:0]}};
            end
            default: begin
                beReq    = 4'b1111;
                wdataReq = store_data;
            end
        endcase
    end

    // Pick the addressed byte/half of the returned word and extend it.
    always_comb begin
        selByte = dmem_rdata[7:0];
        case (offset_q)
            2'd0: selByte = dmem_rdata[7:0];
            2'd1: selByte = dmem_rdata[15:8];
            2'd2: selByte = dmem_rdata[23:16];
            2'd3: selByte = dmem_rdata[31:24];
            default: selByte = dmem_rdata[7:0];
        endcase
        selHalf = offset_q[1] ? dmem_rdata[31:16] : dmem_rdata[15:0];
        case (funct3_q)
            3'b000:  fmtData = {{24{selByte[7]}}, selByte};
            3'b001:  fmtData = {{16{selHalf[15]}}, selHalf};
            3'b100:  fmtData = {24'h0, selByte};
            3'b101:  fmtData = {16'h0, selHalf};
            default: fmtData = dmem_rdata;
        endcase
    end

`ifdef LSU_TIMEOUT_EN
    localparam logic [7:0] TimeoutLast = 8'(TIMEOUT_CYCLES - 1);

    logic [7:0] waitCnt_q, waitCnt_d;
    logic       waiting;

    assign waiting    = ((state_q == REQ) & ~dmem_ready) | ((state_q == RESP) & ~dmem_rvalid);
    assign timeoutHit = waiting & (waitCnt_q == TimeoutLast);

    // Count waiting cycles; restart whenever REQ or RESP is freshly entered.
    always_comb begin
        waitCnt_d = waitCnt_q;
        if (start | ((state_q == REQ) & dmem_ready)) begin
            waitCnt_d = 8'd0;
        end else if (waiting) begin
            waitCnt_d = waitCnt_q + 8'd1;
        end
    end

    // Wait counter register.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            waitCnt_q <= 8'd0;
        end else begin
            waitCnt_q <= waitCnt_d;
        end
    end
`else
    assign timeoutHit = 1'b0;
`endif

    // Next-state and registered-output logic of the access FSM.
    always_comb begin
        state_d       = state_q;
        dmemReq_d     = dmemReq_q;
        dmemWe_d      = dmemWe_q;
        dmemAddr_d    = dmemAddr_q;
        dmemWdata_d   = dmemWdata_q;
        dmemBe_d      = dmemBe_q;
        funct3_d      = funct3_q;
        offset_d      = offset_q;
        isStore_d     = isStore_q;
        loadData_d    = loadData_q;
        loadValid_d   = 1'b0;
        storeDone_d   = 1'b0;
        accessFault_d = 1'b0;
        case (state_q)
            IDLE: begin
                if (start) begin
                    if (illegal) begin
                        state_d       = DONE;
                        accessFault_d = 1'b1;
                        loadData_d    = 32'h0;
                    end else begin
                        state_d     = REQ;
                        dmemReq_d   = 1'b1;
                        dmemWe_d    = isStore;
                        dmemAddr_d  = {addr[31:2], 2'b00};
                        dmemWdata_d = isStore ? wdataReq : 32'h0;
                        dmemBe_d    = beReq;
                        funct3_d    = funct3;
                        offset_d    = addr[1:0];
                        isStore_d   = isStore;
                    end
                end
            end
            REQ: begin
                if (dmem_ready) begin
                    dmemReq_d = 1'b0;
                    if (isStore_q) begin
                        state_d     = DONE;
                        storeDone_d = 1'b1;
                    end else if (dmem_rvalid) begin
                        state_d     = DONE;
                        loadData_d  = fmtData;
                        loadValid_d = 1'b1;
                    end else begin
                        state_d = RESP;
                    end
                end else if (timeoutHit) begin
                    dmemReq_d     = 1'b0;
                    state_d       = DONE;
                    accessFault_d = 1'b1;
                    loadData_d    = 32'h0;
                end
            end
            RESP: begin
                if (dmem_rvalid) begin
                    state_d     = DONE;
                    loadData_d  = fmtData;
                    loadValid_d = 1'b1;
                end else if (timeoutHit) begin
                    state_d       = DONE;
                    accessFault_d = 1'b1;
                    loadData_d    = 32'h0;
                end
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State and registered outputs; reset clears everything at once.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= IDLE;
            dmemReq_q     <= 1'b0;
            dmemWe_q      <= 1'b0;
            dmemAddr_q    <= 32'h0;
            dmemWdata_q   <= 32'h0;
            dmemBe_q      <= 4'h0;
            funct3_q      <= 3'b000;
            offset_q      <= 2'b00;
            isStore_q     <= 1'b0;
            loadData_q    <= 32'h0;
            loadValid_q   <= 1'b0;
            storeDone_q   <= 1'b0;
            accessFault_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            dmemReq_q     <= dmemReq_d;
            dmemWe_q      <= dmemWe_d;
            dmemAddr_q    <= dmemAddr_d;
            dmemWdata_q   <= dmemWdata_d;
            dmemBe_q      <= dmemBe_d;
            funct3_q      <= funct3_d;
            offset_q      <= offset_d;
            isStore_q     <= isStore_d;
            loadData_q    <= loadData_d;
            loadValid_q   <= loadValid_d;
            storeDone_q   <= storeDone_d;
            accessFault_q <= accessFault_d;
        end
    end

    assign lsu_stall    = start | (state_q == REQ) | (state_q == RESP);
    assign load_data    = loadData_q;
    assign load_valid   = loadValid_q;
    assign store_done   = storeDone_q;
    assign access_fault = accessFault_q;
    assign dmem_req     = dmemReq_q;
    assign dmem_we      = dmemWe_q;
    assign dmem_addr    = dmemAddr_q;
    assign dmem_wdata   = dmemWdata_q;
    assign dmem_be      = dmemBe_q;

endmodule

// File: tb/tb_lsu_dmem_unit.sv
// tb_lsu_dmem_unit: directed bench for lsu_dmem_unit. The bench plays the
// pipeline and the data memory cycle by cycle with hand-computed expectations.
// With LSU_TIMEOUT_EN defined the DUT is built with TIMEOUT_CYCLES=4 and the
// timeout abort is exercised as well.
module tb_lsu_dmem_unit;

`ifdef LSU_TIMEOUT_EN
    localparam int unsigned TbTimeout = 4;
`else
    localparam int unsigned TbTimeout = 255;
`endif

    logic        clk;
    logic        rst_n;
    logic        ex_valid;
    logic        mem_read;
    logic        mem_write;
    logic [2:0]  funct3;
    logic [31:0] addr;
    logic [31:0] store_data;
    logic        lsu_stall;
    logic [31:0] load_data;
    logic        load_valid;
    logic        store_done;
    logic        access_fault;
    logic        dmem_req;
    logic        dmem_we;
    logic [31:0] dmem_addr;
    logic [31:0] dmem_wdata;
    logic [3:0]  dmem_be;
    logic        dmem_ready;
    logic        dmem_rvalid;
    logic [31:0] dmem_rdata;

    int compCnt;
    int errCnt;
    int stallCnt;

    lsu_dmem_unit #(.TIMEOUT_CYCLES(TbTimeout)) dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .ex_valid     (ex_valid),
        .mem_read     (mem_read),
        .mem_write    (mem_write),
        .funct3       (funct3),
        .addr         (addr),
        .store_data   (store_data),
        .lsu_stall    (lsu_stall),
        .load_data    (load_data),
        .load_valid   (load_valid),
        .store_done   (store_done),
        .access_fault (access_fault),
        .dmem_req     (dmem_req),
        .dmem_we      (dmem_we),
        .dmem_addr    (dmem_addr),
        .dmem_wdata   (dmem_wdata),
        .dmem_be      (dmem_be),
        .dmem_ready   (dmem_ready),
        .dmem_rvalid  (dmem_rvalid),
        .dmem_rdata   (dmem_rdata)
    );

    // 10 ns clock.
    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Single comparison point for the whole bench.
    task automatic checkOutput(input string tag, input logic [31:0] observed, input logic [31:0] expected);
        compCnt++;
        if (observed !== expected) begin
            errCnt++;
            $display("[TB] FAIL %s: got 0x%08h, expected 0x%08h", tag, observed, expected);
        end
    endtask

    // Present a new instruction from EX/MEM.
    task automatic applyStimulus(input logic rd, input logic wr, input logic [2:0] f3,
                                 input logic [31:0] a, input logic [31:0] sd);
        ex_valid   = 1'b1;
        mem_read   = rd;
        mem_write  = wr;
        funct3     = f3;
        addr       = a;
        store_data = sd;
    endtask

    // The pipeline advances: no memory instruction in MEM any more.
    task automatic releaseStage();
        ex_valid  = 1'b0;
        mem_read  = 1'b0;
        mem_write = 1'b0;
    endtask

    // One clock: count stall at mid-cycle, return 1 ns after the next edge.
    task automatic tick();
        @(negedge clk);
        if (lsu_stall) stallCnt++;
        @(posedge clk);
        #1;
    endtask

    // Load against a memory that answers ready and rvalid in the first REQ cycle.
    task automatic zeroWaitLoad(input string tag, input logic [2:0] f3, input logic [31:0] a,
                                input logic [31:0] expAddr, input logic [3:0] expBe,
                                input logic [31:0] rdata, input logic [31:0] expData);
        stallCnt = 0;
        applyStimulus(1'b1, 1'b0, f3, a, 32'h0);
        tick();
        checkOutput({tag, "_req"}, {31'h0, dmem_req}, 32'h1);
        checkOutput({tag, "_addr"}, dmem_addr, expAddr);
        checkOutput({tag, "_be"}, {28'h0, dmem_be}, {28'h0, expBe});
        checkOutput({tag, "_we"}, {31'h0, dmem_we}, 32'h0);
        dmem_ready  = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = rdata;
        tick();
        checkOutput({tag, "_valid"}, {31'h0, load_valid}, 32'h1);
        checkOutput({tag, "_data"}, load_data, expData);
        checkOutput({tag, "_reqDrop"}, {31'h0, dmem_req}, 32'h0);
        releaseStage();
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        tick();
        checkOutput({tag, "_validPulse"}, {31'h0, load_valid}, 32'h0);
        checkOutput({tag, "_stall"}, stallCnt, 32'd2);
    endtask

    // Access rejected in IDLE: one fault pulse, no request, one stall cycle.
    task automatic illegalAccess(input string tag, input logic rd, input logic wr,
                                 input logic [2:0] f3, input logic [31:0] a);
        stallCnt = 0;
        applyStimulus(rd, wr, f3, a, 32'hFFFF_FFFF);
        tick();
        checkOutput({tag, "_fault"}, {31'h0, access_fault}, 32'h1);
        checkOutput({tag, "_noReq"}, {31'h0, dmem_req}, 32'h0);
        checkOutput({tag, "_data"}, load_data, 32'h0);
        releaseStage();
        tick();
        checkOutput({tag, "_faultPulse"}, {31'h0, access_fault}, 32'h0);
        checkOutput({tag, "_stall"}, stallCnt, 32'd1);
    endtask

    initial begin
        compCnt     = 0;
        errCnt      = 0;
        stallCnt    = 0;
        rst_n       = 1'b0;
        dmem_ready  = 1'b0;
        dmem_rvalid = 1'b0;
        dmem_rdata  = 32'h0;
        funct3      = 3'b000;
        addr        = 32'h0;
        store_data  = 32'h0;
        releaseStage();

        // Reset state.
        repeat (2) @(posedge clk);
        #1;
        checkOutput("rst_req", {31'h0, dmem_req}, 32'h0);
        checkOutput("rst_data", load_data, 32'h0);
        checkOutput("rst_stall", {31'h0, lsu_stall}, 32'h0);
        checkOutput("rst_be", {28'h0, dmem_be}, 32'h0);
        checkOutput("rst_addr", dmem_addr, 32'h0);
        checkOutput("rst_pulses", {29'h0, load_valid, store_done, access_fault}, 32'h0);
        rst_n = 1'b1;
        tick();

        // Zero-wait loads: word, signed/unsigned byte, signed half.
        zeroWaitLoad("lw100", 3'b010, 32'h0000_0100, 32'h0000_0100, 4'b1111, 32'hDEAD_BEEF, 32'hDEAD_BEEF);
        zeroWaitLoad("lb103", 3'b000, 32'h0000_0103, 32'h0000_0100, 4'b1000, 32'h80FF_0000, 32'hFFFF_FF80);
        zeroWaitLoad("lbu103", 3'b100, 32'h0000_0103, 32'h0000_0100, 4'b1000, 32'h80FF_0000, 32'h0000_0080);
        zeroWaitLoad("lh202", 3'b001, 32'h0000_0202, 32'h0000_0200, 4'b1100, 32'h8001_1234, 32'hFFFF_8001);

        // SH with ready arriving on the third REQ cycle.
        stallCnt = 0;
        applyStimulus(1'b0, 1'b1, 3'b001, 32'h0000_0022, 32'h1234_ABCD);
        tick();
        for (int i = 0; i < 2; i++) begin
            checkOutput("sh_req", {31'h0, dmem_req}, 32'h1);
            checkOutput("sh_we", {31'h0, dmem_we}, 32'h1);
            checkOutput("sh_addr", dmem_addr, 32'h0000_0020);
            checkOutput("sh_wdata", dmem_wdata, 32'hABCD_ABCD);
            checkOutput("sh_be", {28'h0, dmem_be}, 32'h0000_000C);
            checkOutput("sh_noDone", {31'h0, store_done}, 32'h0);
            tick();
        end
        checkOutput("sh_reqHeld", {31'h0, dmem_req}, 32'h1);
        dmem_ready = 1'b1;
        tick();
        checkOutput("sh_done", {31'h0, store_done}, 32'h1);
        checkOutput("sh_reqDrop", {31'h0, dmem_req}, 32'h0);
        checkOutput("sh_noLoadValid", {31'h0, load_valid}, 32'h0);
        checkOutput("sh_loadDataKept", load_data, 32'hFFFF_8001);
        releaseStage();
        dmem_ready = 1'b0;
        tick();
        checkOutput("sh_donePulse", {31'h0, store_done}, 32'h0);
        checkOutput("sh_stall", stallCnt, 32'd4);

        // SB zero-wait: byte replicated, enable on lane 1.
        stallCnt = 0;
        applyStimulus(1'b0, 1'b1, 3'b000, 32'h0000_0041, 32'h0000_00A5);
        tick();
        checkOutput("sb_wdata", dmem_wdata, 32'hA5A5_A5A5);
        checkOutput("sb_be", {28'h0, dmem_be}, 32'h0000_0002);
        dmem_ready = 1'b1;
        tick();
        checkOutput("sb_done", {31'h0, store_done}, 32'h1);
        releaseStage();
        dmem_ready = 1'b0;
        tick();
        checkOutput("sb_stall", stallCnt, 32'd2);

        // Illegal accesses.
        illegalAccess("lw102", 1'b1, 1'b0, 3'b010, 32'h0000_0102);
        illegalAccess("lh101", 1'b1, 1'b0, 3'b001, 32'h0000_0101);
        illegalAccess("f3_011", 1'b1, 1'b0, 3'b011, 32'h0000_0100);
        illegalAccess("sbu", 1'b0, 1'b1, 3'b100, 32'h0000_0100);

        // LHU through RESP: ready in REQ cycle, rvalid two cycles later.
        stallCnt = 0;
        applyStimulus(1'b1, 1'b0, 3'b101, 32'h0000_0200, 32'h0);
        tick();
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        checkOutput("lhu_respNoReq", {31'h0, dmem_req}, 32'h0);
        checkOutput("lhu_respNoValid", {31'h0, load_valid}, 32'h0);
        tick();
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'hFFFF_8001;
        tick();
        checkOutput("lhu_valid", {31'h0, load_valid}, 32'h1);
        checkOutput("lhu_data", load_data, 32'h0000_8001);
        releaseStage();
        dmem_rvalid = 1'b0;
        tick();
        checkOutput("lhu_stall", stallCnt, 32'd4);

        // Reset while REQ is pending: req drops without waiting for an edge.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        checkOutput("rstReq_pending", {31'h0, dmem_req}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        checkOutput("rstReq_reqDrop", {31'h0, dmem_req}, 32'h0);
        checkOutput("rstReq_addr", dmem_addr, 32'h0);
        releaseStage();
        @(posedge clk);
        #1;
        rst_n = 1'b1;

        // Reset while in RESP, followed by a stale rvalid in IDLE.
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0300, 32'h0);
        tick();
        dmem_ready = 1'b1;
        tick();
        dmem_ready = 1'b0;
        checkOutput("rstResp_inResp", {31'h0, lsu_stall}, 32'h1);
        #2 rst_n = 1'b0;
        #1;
        releaseStage();
        #1;
        checkOutput("rstResp_idle", {31'h0, lsu_stall}, 32'h0);
        checkOutput("rstResp_req", {31'h0, dmem_req}, 32'h0);
        @(posedge clk);
        #1;
        rst_n       = 1'b1;
        dmem_rvalid = 1'b1;
        dmem_rdata  = 32'h1234_5678;
        tick();
        dmem_rvalid = 1'b0;
        checkOutput("stale_noValid", {31'h0, load_valid}, 32'h0);
        checkOutput("stale_data", load_data, 32'h0);
        checkOutput("stale_stall", {31'h0, lsu_stall}, 32'h0);

`ifdef LSU_TIMEOUT_EN
        // Timeout: ready never comes; abort after four waiting cycles.
        stallCnt = 0;
        applyStimulus(1'b1, 1'b0, 3'b010, 32'h0000_0400, 32'h0);
        tick();
        repeat (3) tick();
        checkOutput("to_reqStillHigh", {31'h0, dmem_req}, 32'h1);
        checkOutput("to_noFaultYet", {31'h0, access_fault}, 32'h0);
        tick();
        checkOutput("to_reqDrop", {31'h0, dmem_req}, 32'h0);
        checkOutput("to_fault", {31'h0, access_fault}, 32'h1);
        checkOutput("to_noValid", {31'h0, load_valid}, 32'h0);
        checkOutput("to_data", load_data, 32'h0);
        releaseStage();
        tick();
        checkOutput("to_stallLow", {31'h0, lsu_stall}, 32'h0);
        checkOutput("to_stall", stallCnt, 32'd5);
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compCnt, errCnt);
        $finish;
    end

endmodule
